// File: rtl/matrix_writer_arbiter.sv
// matrix_writer_arbiter: round-robin owner selection for the single matrix
// storage writer. One requester owns the writer from its request through
// write_done. The owner's metadata, data and handshakes are routed
// combinationally, selected by the registered grant_idx.
// Optional feature macro: ARB_TIMEOUT_EN (16-bit watchdog that aborts a
// stalled grant and pulses timeout_err).
//
// Handshakes: write_request is held by the owner until the writer drops
// write_ready. Elements move on each cycle where data_valid is high. The
// writer ends the transfer with a one-cycle write_done pulse. Requesters
// that are not the owner see 0 on every req_* handshake output.
module matrix_writer_arbiter #(
  parameter int NUM_REQ        = 3,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_write_request,
  input  logic [NUM_REQ*3-1:0]          req_matrix_id,
  input  logic [NUM_REQ*8-1:0]          req_actual_rows,
  input  logic [NUM_REQ*8-1:0]          req_actual_cols,
  input  logic [NUM_REQ*64-1:0]         req_matrix_name,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_in,
  input  logic [NUM_REQ-1:0]            req_data_valid,
  output logic [NUM_REQ-1:0]            req_write_ready,
  output logic [NUM_REQ-1:0]            req_writer_ready,
  output logic [NUM_REQ-1:0]            req_write_done,
  output logic                          write_request,
  output logic [2:0]                    matrix_id,
  output logic [7:0]                    actual_rows,
  output logic [7:0]                    actual_cols,
  output logic [63:0]                   matrix_name,
  output logic [DATA_WIDTH-1:0]         data_in,
  output logic                          data_valid,
  input  logic                          write_ready,
  input  logic                          writer_ready,
  input  logic                          write_done,
  output logic                          busy,
  output logic [$clog2(NUM_REQ)-1:0]    grant_idx,
  output logic                          timeout_err,
  output logic [1:0]                    state_dbg
);

  localparam int GW = $clog2(NUM_REQ);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_GRANT   = 2'd1,
    S_XFER    = 2'd2,
    S_RELEASE = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [GW-1:0] grant_idx_q, grant_idx_d;
  logic [GW-1:0] last_q, last_d;
  logic          busy_q, busy_d;

  // Round-robin candidate search results
  logic          found;
  logic [GW-1:0] sel;
  logic [GW-1:0] cand;

`ifdef ARB_TIMEOUT_EN
  localparam logic [15:0] WD_LIMIT = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] wd_q, wd_d;
  logic        timeout_err_q, timeout_err_d;
`endif

  // State register with asynchronous reset; pointer starts at NUM_REQ-1 so requester 0 wins first
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      grant_idx_q <= '0;
      last_q      <= GW'(NUM_REQ - 1);
      busy_q      <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      wd_q          <= '0;
      timeout_err_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      grant_idx_q <= grant_idx_d;
      last_q      <= last_d;
      busy_q      <= busy_d;
`ifdef ARB_TIMEOUT_EN
      wd_q          <= wd_d;
      timeout_err_q <= timeout_err_d;
`endif
    end
  end

  // Next-state logic: arbitration in IDLE, hold through the transfer, pointer update on release
  always_comb begin
    state_d     = state_q;
    grant_idx_d = grant_idx_q;
    last_d      = last_q;
    busy_d      = busy_q;
    found       = 1'b0;
    sel         = last_q;
    cand        = '0;
    // Search last+1, last+2, ... wrapping, so the last owner is checked last
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = GW'((int'(last_q) + k) % NUM_REQ);
      if (!found && req_write_request[cand]) begin
        found = 1'b1;
        sel   = cand;
      end
    end
    case (state_q)
      S_IDLE: begin
        if (write_ready && found) begin
          grant_idx_d = sel;
          busy_d      = 1'b1;
          state_d     = S_GRANT;
        end
      end
      S_GRANT: begin
        if (!write_ready) begin
          state_d = S_XFER;
        end else if (!req_write_request[grant_idx_q]) begin
          // Requester withdrew before the writer took it; pointer is left alone
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end
      end
      S_XFER: begin
        if (write_done) state_d = S_RELEASE;
      end
      S_RELEASE: begin
        last_d  = grant_idx_q;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
`ifdef ARB_TIMEOUT_EN
    wd_d          = wd_q;
    timeout_err_d = 1'b0;
    if (state_q == S_IDLE && state_d == S_GRANT) begin
      wd_d = '0;
    end else if ((state_q == S_GRANT) || (state_q == S_XFER && !write_done)) begin
      if (wd_q == WD_LIMIT) begin
        // Stalled grant: release it without signalling completion
        timeout_err_d = 1'b1;
        state_d       = S_RELEASE;
      end else begin
        wd_d = wd_q + 16'd1;
      end
    end
`endif
  end

  // Output routing: only the owner's lanes are forwarded, and only in the phase they belong to
  always_comb begin
    write_request    = 1'b0;
    matrix_id        = '0;
    actual_rows      = '0;
    actual_cols      = '0;
    matrix_name      = '0;
    data_in          = '0;
    data_valid       = 1'b0;
    req_write_ready  = '0;
    req_writer_ready = '0;
    req_write_done   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_idx_q == GW'(i)) begin
        if (state_q == S_GRANT || state_q == S_XFER) begin
          matrix_id          = req_matrix_id[3*i +: 3];
          actual_rows        = req_actual_rows[8*i +: 8];
          actual_cols        = req_actual_cols[8*i +: 8];
          matrix_name        = req_matrix_name[64*i +: 64];
          req_write_ready[i] = write_ready;
        end
        if (state_q == S_GRANT) begin
          write_request = req_write_request[i];
        end
        if (state_q == S_XFER) begin
          data_in             = req_data_in[DATA_WIDTH*i +: DATA_WIDTH];
          data_valid          = req_data_valid[i];
          req_writer_ready[i] = writer_ready;
          req_write_done[i]   = write_done;
        end
      end
    end
  end

  assign busy      = busy_q;
  assign grant_idx = grant_idx_q;
  assign state_dbg = state_q;
`ifdef ARB_TIMEOUT_EN
  assign timeout_err = timeout_err_q;
`else
  assign timeout_err = 1'b0;
`endif

endmodule

// File: doc/matrix_writer_arbiter.md
Name: matrix_writer_arbiter

Overview:
Shares the single matrix storage writer between NUM_REQ producers: the random-generation handler, the manual-input handler and the compute-result path. Round-robin arbitration; a grant is held for a whole matrix transfer, from request through write_done. Forwards the granted requester's metadata and data stream to the writer, and routes the writer's handshakes back to that requester only. Sits between the handlers and the matrix writer in the storage subsystem.

Parameters:
NUM_REQ, 3, number of requesters (2..8)
DATA_WIDTH, 32, matrix element width
TIMEOUT_CYCLES, 65535, watchdog limit (used only with ARB_TIMEOUT_EN)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous active-high reset
req_write_request  input  NUM_REQ  per-requester write request
req_matrix_id  input  NUM_REQ*3  per-requester slot id, requester i at [3i+2:3i]
req_actual_rows  input  NUM_REQ*8  per-requester row count
req_actual_cols  input  NUM_REQ*8  per-requester column count
req_matrix_name  input  NUM_REQ*64  per-requester 8-byte name, byte 0 at [64i+7:64i]
req_data_in  input  NUM_REQ*DATA_WIDTH  per-requester element data
req_data_valid  input  NUM_REQ  per-requester element strobe
req_write_ready  output  NUM_REQ  writer idle, visible to the granted requester only
req_writer_ready  output  NUM_REQ  writer accepting data, visible to the granted requester only
req_write_done  output  NUM_REQ  transfer-complete pulse, visible to the granted requester only
write_request  output  1  to writer
matrix_id  output  3  to writer
actual_rows  output  8  to writer
actual_cols  output  8  to writer
matrix_name  output  64  to writer
data_in  output  DATA_WIDTH  to writer
data_valid  output  1  to writer
write_ready  input  1  from writer, high when idle
writer_ready  input  1  from writer
write_done  input  1  from writer, one-cycle pulse
busy  output  1  a grant is active
grant_idx  output  $clog2(NUM_REQ)  index of the current/last grant
timeout_err  output  1  watchdog abort pulse (ARB_TIMEOUT_EN only, else tied 0)

Behaviour:
- Reset (async, rst=1): state IDLE, busy=0, grant_idx=0, round-robin pointer last=NUM_REQ-1 so requester 0 has first priority, timeout_err=0.
- In IDLE all writer-side outputs are 0 and all req_* outputs are 0.
- Combinational paths: metadata, data and handshakes are muxed combinationally from the registered grant_idx. The only registered outputs are busy, grant_idx and timeout_err.
- States: IDLE, GRANT, XFER, RELEASE.
- IDLE: when write_ready=1 and any req_write_request bit is set, select the first set bit searching from last+1 modulo NUM_REQ. Register grant_idx and set busy=1 next cycle, then go to GRANT. Latency is one cycle from request to forwarded write_request.
- GRANT:
  - write_request = req_write_request[g]; metadata is forwarded from requester g.
  - If write_ready falls (writer accepted), go to XFER.
  - If req_write_request[g] drops while write_ready is still 1, abandon: go to IDLE, busy=0, pointer unchanged.
- XFER:
  - data_in and data_valid are forwarded from requester g.
  - req_writer_ready[g]=writer_ready and req_write_ready[g]=write_ready.
  - On write_done=1, req_write_done[g]=1 in the same cycle; go to RELEASE.
- RELEASE: one cycle. last<=grant_idx, busy<=0, go to IDLE. grant_idx keeps its value.
- Fairness: while requester g is being served, requests from other requesters are only sampled in IDLE after RELEASE. A requester whose request stays asserted through RELEASE is re-eligible, but at lowest priority.
- Non-granted requesters always see 0 on all three req_* handshake outputs.
- write_done outside XFER is ignored.
- Reset mid-transfer: state returns to IDLE immediately; the writer sees write_request=0 and data_valid=0 from the reset assertion onward.

Optional Feature:
ARB_TIMEOUT_EN:
- Defined: a 16-bit watchdog clears on entry to GRANT and increments each cycle in GRANT/XFER. On reaching TIMEOUT_CYCLES, timeout_err pulses for one cycle, the state goes to RELEASE (pointer advances) and req_write_done[g] is not asserted.
- Undefined: no counter, timeout_err tied 0, a grant waits indefinitely.

Test Plan:
- Single requester: req 1 requests a 2x3 matrix with id 2; writer acks and streams 6 elements; write_done pulses. Expect grant_idx=1, 6 forwarded data_valid beats, req_write_done=3'b010 for exactly one cycle, busy returns to 0.
- Simultaneous requests on all 3 from reset: grants occur in order 0,1,2, each held until its write_done. Requesters held high again afterwards are granted 0,1,2 again.
- Isolation: while requester 0 is granted, requester 2 asserts data_valid=1 with data 0xDEAD. Writer data_in must equal requester 0's data, and req_writer_ready[2]=0 throughout.
- Abandon: requester 0 asserts and drops its request while write_ready=1. Expect return to IDLE, then requester 0 still wins the next simultaneous request with requester 1.
- Reset asserted mid-XFER after 3 of 6 beats: outputs go to 0 asynchronously and busy=0. After release, a new request is granted normally.
- ARB_TIMEOUT_EN with TIMEOUT_CYCLES=20 and the writer never pulsing write_done: timeout_err pulses about 20 cycles after grant, busy=0, and the next requester is granted.
